sqrt_unit: RTL

Parametrised, pipelined-handshake integer square-root engine that produces the floor root and the remainder of an unsigned operand. The input can optionally be extended by fractional bits, and the engine can resolve one or two root bits per cycle. It sits behind the accelerator bus interface as the compute core. It replaces the fixed 32-bit, start/done-pulse core with a valid/ready stream interface that tolerates backpressure.

---
 rtl/sqrt_unit_if.sv | 33 +++
 rtl/sqrt_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sqrt_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt_unit_if
//  Purpose  : Valid/ready stream bundle between a producer/consumer and the
//             sqrt_unit compute core.
//  Ports    : master - drives in_valid, radicand, out_ready
//             slave  - drives in_ready, out_valid, root, remainder, busy
//  Revision : 1.0 - initial release
// ============================================================================
interface sqrt_unit_if #(
    parameter int WIDTH  = 32,
    parameter int ROOT_W = 16
) ();
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  radicand;
    logic              out_valid;
    logic              out_ready;
    logic [ROOT_W-1:0] root;
    logic [ROOT_W:0]   remainder;
    logic              busy;

    modport master (
        output in_valid, radicand, out_ready,
        input  in_ready, out_valid, root, remainder, busy
    );

    modport slave (
        input  in_valid, radicand, out_ready,
        output in_ready, out_valid, root, remainder, busy
    );
endinterface
`default_nettype wire

// File: rtl/sqrt_unit.sv
`default_nettype none
// ============================================================================
//  Module   : sqrt_unit
//  Purpose  : Iterative integer square root (floor root + remainder) of an
//             unsigned radicand, optionally extended by fractional root bits,
//             resolving BITS_PER_CYCLE root bits per clock behind a
//             valid/ready stream interface.
//  Ports    : clk   - rising-edge clock
//             rst   - asynchronous active-high reset
//             clear - synchronous abort back to IDLE, result dropped
//             bus   - sqrt_unit_if.slave (in_valid/in_ready/radicand,
//                     out_valid/out_ready/root/remainder, busy)
//  Revision : 1.0 - initial release
// ============================================================================
module sqrt_unit #(
    parameter int WIDTH          = 32,
    parameter int FRAC_BITS      = 0,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    sqrt_unit_if.slave bus
);

    localparam int ROOT_W = WIDTH / 2 + FRAC_BITS;
    localparam int ITER   = ROOT_W / BITS_PER_CYCLE;
    localparam int EXT_W  = 2 * ROOT_W;           // radicand plus fractional zeros
    localparam int ACC_W  = ROOT_W + 2;           // keeps the trial sign bit
    localparam int CNT_W  = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [EXT_W-1:0]  r_opnd;
    logic [ACC_W-1:0]  r_ac;
    logic [ROOT_W-1:0] r_q;
    logic [CNT_W-1:0]  r_cnt;
    logic [ROOT_W-1:0] r_root;
    logic [ROOT_W:0]   r_rem;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_busy;
    logic              w_accept;
    logic              w_last;
    logic [EXT_W-1:0]  w_ext;

    // ------------------------------------------------------------------------
    // Digit recurrence, unrolled BITS_PER_CYCLE times per clock
    // ------------------------------------------------------------------------
    logic [ACC_W-1:0]  w_ac [0:BITS_PER_CYCLE];
    logic [ROOT_W-1:0] w_q  [0:BITS_PER_CYCLE];
    logic [EXT_W-1:0]  w_op [0:BITS_PER_CYCLE];

    assign w_ac[0] = r_ac;
    assign w_q[0]  = r_q;
    assign w_op[0] = r_opnd;

    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        logic [ACC_W-1:0] w_shift;
        logic [ACC_W-1:0] w_trial;
        logic             w_unused_hi;

        // The partial remainder never exceeds 2*q, so its two MSBs are
        // always zero before the shift and can be dropped safely.
        assign w_shift     = {w_ac[k][ACC_W-3:0], w_op[k][EXT_W-1 -: 2]};
        assign w_trial     = w_shift - {w_q[k], 2'b01};
        assign w_ac[k+1]   = w_trial[ACC_W-1] ? w_shift : w_trial;
        assign w_q[k+1]    = {w_q[k][ROOT_W-2:0], ~w_trial[ACC_W-1]};
        assign w_op[k+1]   = w_op[k] << 2;
        assign w_unused_hi = ^w_ac[k][ACC_W-1 -: 2];
    end

    assign w_ext    = EXT_W'(bus.radicand) << (2 * FRAC_BITS);
    assign w_last   = (r_cnt == c_LAST);
    assign w_accept = bus.in_valid & w_in_ready;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic (clear overrides everything)
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        w_state_nxt = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    // Consume and optionally accept the next operand on the
                    // same edge.
                    if (bus.out_ready) begin
                        w_state_nxt = bus.in_valid ? S_BUSY : S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: w_in_ready = 1'b1;
            S_BUSY: w_busy     = 1'b1;
            S_DONE: begin
                w_out_valid = 1'b1;
                w_in_ready  = bus.out_ready;
            end
            default: w_in_ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opnd <= '0;
            r_ac   <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_root <= '0;
            r_rem  <= '0;
        end else if (clear) begin
            r_opnd <= '0;
            r_ac   <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_root <= '0;
            r_rem  <= '0;
        end else if (w_accept) begin
            r_opnd <= w_ext;
            r_ac   <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
        end else if (r_state == S_BUSY) begin
            r_opnd <= w_op[BITS_PER_CYCLE];
            r_ac   <= w_ac[BITS_PER_CYCLE];
            r_q    <= w_q[BITS_PER_CYCLE];
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
                // Remainder <= 2*root, so ROOT_W+1 bits always hold it.
                r_root <= w_q[BITS_PER_CYCLE];
                r_rem  <= w_ac[BITS_PER_CYCLE][ROOT_W:0];
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.root      = r_root;
    assign bus.remainder = r_rem;

endmodule
`default_nettype wire
